adc_pattern_gen: RTL and testbench



---
 rtl/adc_pattern_gen.sv | 187 ++++++++++++++++++
 tb/tb_adc_pattern_gen.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_pattern_gen.sv
// Multi-channel ADC data emulator: per-channel sine / ramp / PRBS / constant sources
// producing offset-binary samples with over-range flags behind a fixed-latency pipeline.
module adc_pattern_gen #(
    parameter int NCH = 2,
    parameter int DW = 14,
    parameter int PHASE_W = 32,
    parameter int LUT_AW = 10,
    parameter logic [PHASE_W-1:0] DEF_INC = PHASE_W'(330382099),
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                run,
    input  logic                start,
    input  logic                sample_en,
    input  logic                cfg_we,
    input  logic [CW-1:0]       cfg_ch,
    input  logic [1:0]          cfg_addr,
    input  logic [PHASE_W-1:0]  cfg_wdata,
    output logic [NCH*DW-1:0]   dout,
    output logic [NCH-1:0]      dout_of,
    output logic                dout_valid
);

    localparam int ROM_N = 2 ** LUT_AW;
    localparam real PI = 3.14159265358979323846;
    localparam real MID = real'(2 ** (DW - 1));
    localparam real AMP = real'(2 ** (DW - 1) - 1);
    localparam logic [DW-1:0] CONST_RST = {1'b1, {(DW - 1){1'b0}}};

    // Full-wave sine table, evaluated at elaboration and shared by every channel.
    logic [DW-1:0] sine_rom [ROM_N];

    genvar gi;
    generate
        for (gi = 0; gi < ROM_N; gi++) begin : g_rom
            localparam int VAL = $rtoi(MID + AMP * $sin(2.0 * PI * real'(gi) / real'(ROM_N)) + 0.5);
            assign sine_rom[gi] = VAL[DW-1:0];
        end
    endgenerate

    logic accept;
    assign accept = sample_en && run && !start;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic dout_valid_q, dout_valid_d;

    always_comb begin
        s1_valid_d   = accept;
        s2_valid_d   = s1_valid_q;
        dout_valid_d = s2_valid_q;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout_valid = dout_valid_q;

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            localparam logic [14:0] SEED = 15'(gi + 1);

            logic [1:0]         mode_q, mode_d;
            logic [PHASE_W-1:0] inc_q, inc_d;
            logic [PHASE_W-1:0] off_q, off_d;
            logic [DW-1:0]      cval_q, cval_d;
            logic [PHASE_W-1:0] acc_q, acc_d;
            logic [14:0]        lfsr_q, lfsr_d;
            logic [LUT_AW-1:0]  s1_addr_q, s1_addr_d;
            logic [DW-1:0]      s1_val_q, s1_val_d;
            logic               s1_sine_q, s1_sine_d;
            logic [DW-1:0]      s2_data_q, s2_data_d;
            logic [DW-1:0]      dout_ch_q, dout_ch_d;
            logic               of_q, of_d;
            logic [PHASE_W-1:0] phase;
            logic [DW-1:0]      prbs_val;
            logic               wr_sel;

            if (DW <= 15) begin : g_prbs_n
                assign prbs_val = lfsr_q[DW-1:0];
            end else begin : g_prbs_w
                assign prbs_val = {{(DW - 15){1'b0}}, lfsr_q};
            end

            // Out-of-range channel indices never match any gi, so those writes fall away.
            assign wr_sel = cfg_we && (32'(cfg_ch) == gi);
            assign phase  = acc_q + off_q;

            always_comb begin
                mode_d    = mode_q;
                inc_d     = inc_q;
                off_d     = off_q;
                cval_d    = cval_q;
                acc_d     = acc_q;
                lfsr_d    = lfsr_q;
                s1_addr_d = s1_addr_q;
                s1_val_d  = s1_val_q;
                s1_sine_d = s1_sine_q;
                s2_data_d = s2_data_q;
                dout_ch_d = dout_ch_q;
                of_d      = of_q;

                if (wr_sel) begin
                    case (cfg_addr)
                        2'd0:    mode_d = cfg_wdata[1:0];
                        2'd1:    inc_d  = cfg_wdata;
                        2'd2:    off_d  = cfg_wdata;
                        default: cval_d = cfg_wdata[DW-1:0];
                    endcase
                end

                if (start) begin
                    acc_d  = '0;
                    lfsr_d = SEED;
                end else if (accept) begin
                    acc_d  = acc_q + inc_q;
                    lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
                end

                if (accept) begin
                    s1_addr_d = phase[PHASE_W-1 -: LUT_AW];
                    s1_sine_d = (mode_q == 2'd0);
                    case (mode_q)
                        2'd1:    s1_val_d = phase[PHASE_W-1 -: DW];
                        2'd2:    s1_val_d = prbs_val;
                        2'd3:    s1_val_d = cval_q;
                        default: s1_val_d = '0;
                    endcase
                end

                // Registered ROM read; non-sine values ride along to keep all modes aligned.
                if (s1_valid_q) begin
                    s2_data_d = s1_sine_q ? sine_rom[s1_addr_q] : s1_val_q;
                end

                if (s2_valid_q) begin
                    dout_ch_d = s2_data_q;
                    of_d      = (s2_data_q == '0) || (s2_data_q == '1);
                end
            end

            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    mode_q    <= '0;
                    inc_q     <= DEF_INC;
                    off_q     <= '0;
                    cval_q    <= CONST_RST;
                    acc_q     <= '0;
                    lfsr_q    <= SEED;
                    s1_addr_q <= '0;
                    s1_val_q  <= '0;
                    s1_sine_q <= 1'b0;
                    s2_data_q <= '0;
                    dout_ch_q <= '0;
                    of_q      <= 1'b0;
                end else begin
                    mode_q    <= mode_d;
                    inc_q     <= inc_d;
                    off_q     <= off_d;
                    cval_q    <= cval_d;
                    acc_q     <= acc_d;
                    lfsr_q    <= lfsr_d;
                    s1_addr_q <= s1_addr_d;
                    s1_val_q  <= s1_val_d;
                    s1_sine_q <= s1_sine_d;
                    s2_data_q <= s2_data_d;
                    dout_ch_q <= dout_ch_d;
                    of_q      <= of_d;
                end
            end

            assign dout[gi*DW +: DW] = dout_ch_q;
            assign dout_of[gi]       = of_q;
        end
    endgenerate

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Bench for adc_pattern_gen: reference model feeds a scoreboard of expected samples,
// table-driven config/sample vectors plus hand sequences for PRBS, default sine and reset.
module tb_adc_pattern_gen;

    localparam int NCH = 3;
    localparam int DW = 14;
    localparam logic [31:0] DEF_INC = 32'd330382099;

    logic              sys_clk;
    logic              sys_rst;
    logic              run;
    logic              start;
    logic              sample_en;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [1:0]        cfg_addr;
    logic [31:0]       cfg_wdata;
    logic [NCH*DW-1:0] dout;
    logic [NCH-1:0]    dout_of;
    logic              dout_valid;

    adc_pattern_gen #(.NCH(NCH), .DW(DW), .PHASE_W(32), .LUT_AW(10), .DEF_INC(DEF_INC)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .run(run), .start(start),
        .sample_en(sample_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .dout(dout), .dout_of(dout_of), .dout_valid(dout_valid)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        se, st, rn, we;
        logic [1:0]  ch, addr;
        logic [31:0] wd;
        logic        hk;
        logic [13:0] k0, k1;
    } vec_t;

    typedef struct {
        int              cyc;
        logic [NCH*DW-1:0] dout;
        logic [NCH-1:0]  of;
        logic            hk;
        logic [13:0]     k0, k1;
    } sb_t;

    sb_t         sb[$];
    vec_t        tbl[$];
    logic [13:0] obs0[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic [1:0]  m_mode[NCH];
    logic [31:0] m_inc[NCH];
    logic [31:0] m_off[NCH];
    logic [13:0] m_cval[NCH];
    logic [31:0] m_acc[NCH];
    logic [14:0] m_lfsr[NCH];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [13:0] sine_ref(input logic [9:0] a);
        real x;
        x = 8192.0 + 8191.0 * $sin(2.0 * 3.14159265358979323846 * real'(a) / 1024.0);
        return 14'($rtoi(x + 0.5));
    endfunction

    function automatic logic [13:0] model_sample(input int c);
        logic [31:0] ph;
        ph = m_acc[c] + m_off[c];
        case (m_mode[c])
            2'd0:    return sine_ref(ph[31:22]);
            2'd1:    return ph[31:18];
            2'd2:    return m_lfsr[c][13:0];
            default: return m_cval[c];
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 2'd0;
            m_inc[c]  = DEF_INC;
            m_off[c]  = 32'd0;
            m_cval[c] = 14'd8192;
            m_acc[c]  = 32'd0;
            m_lfsr[c] = 15'(c + 1);
        end
    endtask

    // Scoreboard consumer: each expected sample is due on one exact cycle.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                sb_t e;
                e = sb.pop_front();
                chk("valid_on_time", 64'(dout_valid), 64'd1);
                if (dout_valid) begin
                    obs0.push_back(dout[13:0]);
                    chk("dout_model", 64'(dout), 64'(e.dout));
                    chk("dout_of_model", 64'(dout_of), 64'(e.of));
                    if (e.hk) begin
                        $display("txn cyc=%0d ch0=%0d ch1=%0d of=%b", cyc, dout[13:0], dout[27:14], dout_of);
                        chk("ch0_const", 64'(dout[13:0]), 64'(e.k0));
                        chk("ch1_const", 64'(dout[27:14]), 64'(e.k1));
                    end
                end
            end else if (dout_valid) begin
                chk("valid_spurious", 64'(dout_valid), 64'd0);
            end
        end
    end

    task automatic apply(input vec_t v);
        sb_t e;
        logic [13:0] val;
        sample_en = v.se;
        start     = v.st;
        run       = v.rn;
        cfg_we    = v.we;
        cfg_ch    = v.ch;
        cfg_addr  = v.addr;
        cfg_wdata = v.wd;
        if (v.se && v.rn && !v.st) begin
            e.cyc = cyc + 3;
            e.hk  = v.hk;
            e.k0  = v.k0;
            e.k1  = v.k1;
            e.dout = '0;
            e.of   = '0;
            for (int c = 0; c < NCH; c++) begin
                val = model_sample(c);
                e.dout[c*DW +: DW] = val;
                e.of[c] = (val == 14'd0) || (val == 14'h3fff);
            end
            sb.push_back(e);
            for (int c = 0; c < NCH; c++) begin
                m_acc[c]  = m_acc[c] + m_inc[c];
                m_lfsr[c] = {m_lfsr[c][13:0], m_lfsr[c][14] ^ m_lfsr[c][13]};
            end
        end
        if (v.st) begin
            for (int c = 0; c < NCH; c++) begin
                m_acc[c]  = 32'd0;
                m_lfsr[c] = 15'(c + 1);
            end
        end
        if (v.we && int'(v.ch) < NCH) begin
            case (v.addr)
                2'd0:    m_mode[v.ch] = v.wd[1:0];
                2'd1:    m_inc[v.ch]  = v.wd;
                2'd2:    m_off[v.ch]  = v.wd;
                default: m_cval[v.ch] = v.wd[13:0];
            endcase
        end
        @(posedge sys_clk);
        #1;
    endtask

    function automatic vec_t mk(logic se, logic st, logic rn, logic we, logic [1:0] ch,
                                logic [1:0] addr, logic [31:0] wd, logic hk,
                                logic [13:0] k0, logic [13:0] k1);
        vec_t v;
        v.se = se; v.st = st; v.rn = rn; v.we = we; v.ch = ch; v.addr = addr;
        v.wd = wd; v.hk = hk; v.k0 = k0; v.k1 = k1;
        return v;
    endfunction

    function automatic vec_t vi();
        return mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic vec_t vst();
        return mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic vec_t vw(logic [1:0] ch, logic [1:0] a, logic [31:0] wd);
        return mk(0, 0, 1, 1, ch, a, wd, 0, 0, 0);
    endfunction
    function automatic vec_t vs(logic hk, logic [13:0] k0, logic [13:0] k1);
        return mk(1, 0, 1, 0, 0, 0, 0, hk, k0, k1);
    endfunction
    function automatic vec_t vsw(logic [1:0] ch, logic [1:0] a, logic [31:0] wd,
                                 logic [13:0] k0, logic [13:0] k1);
        return mk(1, 0, 1, 1, ch, a, wd, 1, k0, k1);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(vi());
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int mx, mn;
        // reset sample, sine step, ramp/const, coincident events
        tbl.push_back(vs(1, 14'd8192, 14'd8192));
        for (int i = 0; i < 4; i++) tbl.push_back(vi());
        tbl.push_back(vst());
        tbl.push_back(vw(0, 1, 32'h0040_0000));
        tbl.push_back(vw(1, 1, 32'h0040_0000));
        tbl.push_back(vw(1, 2, 32'h4000_0000));
        tbl.push_back(vs(1, 14'd8192, 14'd16383));
        tbl.push_back(vs(1, 14'd8242, 14'd16383));
        tbl.push_back(vs(1, 14'd8293, 14'd16382));
        for (int i = 0; i < 5; i++) tbl.push_back(vs(0, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(vi());
        tbl.push_back(vw(0, 0, 32'd1));
        tbl.push_back(vw(0, 1, 32'h0004_0000));
        tbl.push_back(vw(1, 0, 32'd3));
        tbl.push_back(vw(1, 3, 32'd16383));
        tbl.push_back(vst());
        tbl.push_back(vs(1, 14'd0, 14'd16383));
        tbl.push_back(vs(1, 14'd1, 14'd16383));
        tbl.push_back(vsw(1, 3, 32'd0, 14'd2, 14'd16383));
        tbl.push_back(vs(1, 14'd3, 14'd0));
        tbl.push_back(vw(1, 3, 32'd5));
        tbl.push_back(vs(1, 14'd4, 14'd5));
        tbl.push_back(vsw(0, 1, 32'h0008_0000, 14'd5, 14'd5));
        tbl.push_back(vs(1, 14'd6, 14'd5));
        tbl.push_back(vs(1, 14'd8, 14'd5));
        tbl.push_back(vw(3, 0, 32'd2));
        tbl.push_back(vw(3, 1, 32'd0));
        tbl.push_back(vw(3, 3, 32'd0));
        tbl.push_back(vs(1, 14'd10, 14'd5));
        for (int i = 0; i < 4; i++) tbl.push_back(vi());
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(vs(1, 14'd0, 14'd5));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(vs(1, 14'd2, 14'd5));
        for (int i = 0; i < 4; i++) tbl.push_back(vi());

        sys_rst = 1'b1; run = 1'b0; start = 1'b0; sample_en = 1'b0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_wdata = '0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        #2;
        chk("reset_dout", 64'(dout), 64'd0);
        chk("reset_dout_of", 64'(dout_of), 64'd0);
        chk("reset_valid", 64'(dout_valid), 64'd0);

        foreach (tbl[i]) apply(tbl[i]);

        // default increment: about two sine periods in 26 samples
        apply(vw(0, 0, 32'd0));
        apply(vw(0, 1, DEF_INC));
        apply(vst());
        idle(4);
        obs0.delete();
        for (int i = 0; i < 26; i++) apply(vs(0, 0, 0));
        idle(4);
        chk("def_inc_count", 64'(obs0.size()), 64'd26);
        mx = 0; mn = 16383;
        foreach (obs0[i]) begin
            if (int'(obs0[i]) > mx) mx = int'(obs0[i]);
            if (int'(obs0[i]) < mn) mn = int'(obs0[i]);
        end
        chk("def_inc_peak_high", 64'(mx > 16000), 64'd1);
        chk("def_inc_trough_low", 64'(mn < 400), 64'd1);

        // PRBS over a full period plus one
        apply(vw(0, 0, 32'd2));
        apply(vw(1, 0, 32'd2));
        apply(vst());
        for (int i = 0; i < 32768; i++) begin
            if (i < 4) apply(vs(1, 14'(1 << i), 14'(2 << i)));
            else if (i == 32767) apply(vs(1, 14'd1, 14'd2));
            else apply(vs(0, 0, 0));
        end
        idle(4);

        // reset asserted with samples in flight
        for (int i = 0; i < 5; i++) apply(vs(0, 0, 0));
        #2;
        sys_rst = 1'b1;
        #1;
        chk("midreset_dout", 64'(dout), 64'd0);
        chk("midreset_dout_of", 64'(dout_of), 64'd0);
        chk("midreset_valid", 64'(dout_valid), 64'd0);
        sb.delete();
        model_reset();
        sample_en = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        idle(4);
        apply(vs(1, 14'd8192, 14'd8192));
        idle(4);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
